// File: rtl/snake_map_writer.sv
// snake_map_writer: writes snake/food/ground tile codes into the 16x16 map RAM.
// Optional: define BODY_CHECK_EN for an occupancy bitmap and self-collision pulse.
module snake_map_writer #(
  parameter int MAX_LEN = 64,
  parameter int INIT_X  = 8,
  parameter int INIT_Y  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_valid,
  output logic       step_ready,
  input  logic [1:0] step_dir,
  input  logic       step_grow,
  input  logic       food_valid,
  output logic       food_ready,
  input  logic [3:0] food_x,
  input  logic [3:0] food_y,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [3:0] wr_data,
  output logic       step_done,
  output logic [6:0] length,
  output logic       hit
);
  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(MAX_LEN);
  localparam logic [PW-1:0] LAST = PW'(MAX_LEN - 1);
  localparam logic [3:0] IX = 4'(INIT_X);
  localparam logic [3:0] IY = 4'(INIT_Y);
  localparam logic [1:0] D_L = 2'd0;
  localparam logic [1:0] D_R = 2'd1;
  localparam logic [1:0] D_U = 2'd2;

  typedef enum logic [3:0] {
    S_CLEAR, S_INIT, S_IDLE, S_FOOD,
    S_TCLR, S_TNEW, S_NECK, S_HEAD, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          run_q, run_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    head_q, head_d;
  logic [7:0]    tail_q, tail_d;
  logic [7:0]    nh_q, nh_d;
  logic [7:0]    food_q, food_d;
  logic [1:0]    cur_q, cur_d;
  logic [1:0]    dir_q, dir_d;
  logic          grow_q, grow_d;
  logic [1:0]    fifo_q [MAX_LEN];
  logic [1:0]    fifo_d [MAX_LEN];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [6:0]    len_q, len_d;
  logic [1:0]    d_sel;
  logic [PW-1:0] rd_nx;
`ifdef BODY_CHECK_EN
  logic [255:0]  occ_q, occ_d;
  logic          hp_q, hp_d;
`endif

  // Positions are packed {y,x}; 4-bit arithmetic gives the wrap for free.
  function automatic logic [7:0] mv(
    input logic [7:0] p,
    input logic [1:0] d
  );
    logic [3:0] x;
    logic [3:0] y;
    x = p[3:0];
    y = p[7:4];
    case (d)
      D_L:     x = x - 4'd1;
      D_R:     x = x + 4'd1;
      D_U:     y = y - 4'd1;
      default: y = y + 4'd1;
    endcase
    return {y, x};
  endfunction

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Corner code is 4 + {down, right} of the two joined sides.
  function automatic logic [3:0] neck(
    input logic [1:0] c,
    input logic [1:0] d
  );
    logic h;
    logic v;
    h = c[1] ? d[0] : ~c[0];
    v = c[1] ? ~c[0] : d[0];
    if (c == d) return c[1] ? 4'h3 : 4'h2;
    return {2'b01, v, h};
  endfunction

  assign rd_nx  = inc(rd_q);
  assign d_sel  = (step_dir == (cur_q ^ 2'd1)) ? cur_q : step_dir;
  assign length = len_q;

  always_comb begin
    state_d    = state_q;
    run_d      = 1'b1;
    cnt_d      = cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    nh_d       = nh_q;
    food_d     = food_q;
    cur_d      = cur_q;
    dir_d      = dir_q;
    grow_d     = grow_q;
    fifo_d     = fifo_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    fcnt_d     = fcnt_q;
    len_d      = len_q;
    wr_en      = 1'b0;
    wr_addr    = 8'd0;
    wr_data    = 4'd0;
    step_done  = 1'b0;
    step_ready = 1'b0;
    food_ready = 1'b0;
    hit        = 1'b0;
`ifdef BODY_CHECK_EN
    occ_d      = occ_q;
    hp_d       = hp_q;
`endif
    unique case (state_q)
      S_CLEAR: begin
        wr_en   = run_q;
        wr_addr = cnt_q;
        if (run_q) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'hFF) state_d = S_INIT;
        end
      end
      S_INIT: begin
        wr_en   = 1'b1;
        wr_addr = {IY, IX - 4'd2 + cnt_q[3:0]};
        wr_data = (cnt_q == 8'd0) ? 4'h9 :
                  (cnt_q == 8'd1) ? 4'h2 : 4'hD;
`ifdef BODY_CHECK_EN
        occ_d[wr_addr] = 1'b1;
`endif
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd2) begin
          state_d   = S_IDLE;
          cnt_d     = 8'd0;
          head_d    = {IY, IX};
          tail_d    = {IY, IX - 4'd2};
          cur_d     = D_R;
          fifo_d[0] = D_R;
          fifo_d[1] = D_R;
          rd_d      = '0;
          wr_d      = inc(inc('0));
          fcnt_d    = CW'(2);
          len_d     = 7'd3;
        end
      end
      S_IDLE: begin
        step_ready = 1'b1;
        food_ready = ~step_valid;
        if (step_valid) begin
          dir_d   = d_sel;
          nh_d    = mv(head_q, d_sel);
          grow_d  = step_grow && (fcnt_q != FULL);
          state_d = (step_grow && (fcnt_q != FULL)) ? S_NECK : S_TCLR;
        end else if (food_valid) begin
          food_d  = {food_y, food_x};
          state_d = S_FOOD;
        end
      end
      S_FOOD: begin
        wr_en   = 1'b1;
        wr_addr = food_q;
        wr_data = 4'h1;
        state_d = S_IDLE;
      end
      S_TCLR: begin
        wr_en   = 1'b1;
        wr_addr = tail_q;
`ifdef BODY_CHECK_EN
        occ_d[tail_q] = 1'b0;
`endif
        state_d = S_TNEW;
      end
      S_TNEW: begin
        tail_d  = mv(tail_q, fifo_q[rd_q]);
        wr_en   = 1'b1;
        wr_addr = tail_d;
        wr_data = {2'b10, fifo_q[rd_nx]};
        rd_d    = rd_nx;
        fcnt_d  = fcnt_q - CW'(1);
        state_d = S_NECK;
      end
      S_NECK: begin
        wr_en   = 1'b1;
        wr_addr = head_q;
        wr_data = neck(cur_q, dir_q);
`ifdef BODY_CHECK_EN
        hp_d = occ_q[nh_q];
`endif
        state_d = S_HEAD;
      end
      S_HEAD: begin
        wr_en   = 1'b1;
        wr_addr = nh_q;
        wr_data = {2'b11, dir_q};
`ifdef BODY_CHECK_EN
        occ_d[nh_q] = 1'b1;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        step_done    = 1'b1;
`ifdef BODY_CHECK_EN
        hit          = hp_q;
`endif
        fifo_d[wr_q] = dir_q;
        wr_d         = inc(wr_q);
        fcnt_d       = fcnt_q + CW'(1);
        cur_d        = dir_q;
        head_d       = nh_q;
        len_d        = len_q + {6'd0, grow_q};
        state_d      = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      run_q   <= 1'b0;
      cnt_q   <= 8'd0;
      head_q  <= 8'd0;
      tail_q  <= 8'd0;
      nh_q    <= 8'd0;
      food_q  <= 8'd0;
      cur_q   <= D_R;
      dir_q   <= D_R;
      grow_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      fcnt_q  <= '0;
      len_q   <= 7'd0;
      for (int i = 0; i < MAX_LEN; i++) fifo_q[i] <= 2'd0;
`ifdef BODY_CHECK_EN
      occ_q   <= '0;
      hp_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      nh_q    <= nh_d;
      food_q  <= food_d;
      cur_q   <= cur_d;
      dir_q   <= dir_d;
      grow_q  <= grow_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fcnt_q  <= fcnt_d;
      len_q   <= len_d;
      fifo_q  <= fifo_d;
`ifdef BODY_CHECK_EN
      occ_q   <= occ_d;
      hp_q    <= hp_d;
`endif
    end
  end

endmodule

// File: tb/tb_snake_map_writer.sv
// tb_snake_map_writer: randomized bench for snake_map_writer.
// Reference snake is a queue of cells (tail first); directions derive from neighbours.
`timescale 1ns/1ps
module tb_snake_map_writer;
  localparam int MAX_LEN = 64;
`ifdef BODY_CHECK_EN
  localparam bit BODY_CHK = 1'b1;
`else
  localparam bit BODY_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_valid = 1'b0;
  logic       step_ready;
  logic [1:0] step_dir = 2'd0;
  logic       step_grow = 1'b0;
  logic       food_valid = 1'b0;
  logic       food_ready;
  logic [3:0] food_x = 4'd0;
  logic [3:0] food_y = 4'd0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [3:0] wr_data;
  logic       step_done;
  logic [6:0] length;
  logic       hit;

  always #5 clk = ~clk;

  snake_map_writer #(
    .MAX_LEN(MAX_LEN),
    .INIT_X (8),
    .INIT_Y (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .step_dir  (step_dir),
    .step_grow (step_grow),
    .food_valid(food_valid),
    .food_ready(food_ready),
    .food_x    (food_x),
    .food_y    (food_y),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .step_done (step_done),
    .length    (length),
    .hit       (hit)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [11:0] wq[$];
  bit          done_seen = 0;
  int          done_cyc = 0;
  logic        hit_seen = 1'b0;
  logic [7:0]  body[$];
  bit          occ[256];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});
    if (step_done === 1'b1) begin
      done_seen = 1;
      done_cyc  = cyc;
      hit_seen  = hit;
    end
  end

  function automatic logic [7:0] mv(input logic [7:0] p, input logic [1:0] d);
    int x;
    int y;
    x = int'(p[3:0]);
    y = int'(p[7:4]);
    if (d == 2'd0) x = (x + 15) % 16;
    else if (d == 2'd1) x = (x + 1) % 16;
    else if (d == 2'd2) y = (y + 15) % 16;
    else y = (y + 1) % 16;
    return {4'(y), 4'(x)};
  endfunction

  function automatic logic [1:0] side(input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < 4; k++)
      if (mv(a, 2'(k)) == b) return 2'(k);
    return 2'd0;
  endfunction

  task automatic run_reset(input string tag);
    int t;
    rst_n = 1'b0;
    step_valid = 1'b0;
    food_valid = 1'b0;
    step_grow = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({wr_en, step_ready, food_ready, step_done, hit, length} !== 12'd0)
      $display("FAIL %s reset_outputs: got %h want 000", tag,
               {wr_en, step_ready, food_ready, step_done, hit, length});
    else n_pass++;
    wq.delete();
    rst_n = 1'b1;
    t = 0;
    while (wq.size() < 259 && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (wq.size() != 259)
      $display("FAIL %s clear_count: got %0d want 259", tag, wq.size());
    else n_pass++;
    for (int i = 0; i < wq.size() && i < 259; i++) begin
      logic [11:0] ex;
      if (i < 256) ex = {8'(i), 4'h0};
      else if (i == 256) ex = 12'h869;
      else if (i == 257) ex = 12'h872;
      else ex = 12'h88D;
      n_chk++;
      if (wq[i] !== ex)
        $display("FAIL %s init_write[%0d]: got %h want %h", tag, i, wq[i], ex);
      else n_pass++;
    end
    t = 0;
    while (step_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (length !== 7'd3)
      $display("FAIL %s init_length: got %0d want 3", tag, length);
    else n_pass++;
    body.delete();
    body.push_back(8'h86);
    body.push_back(8'h87);
    body.push_back(8'h88);
    for (int i = 0; i < 256; i++) occ[i] = 0;
    occ[8'h86] = 1;
    occ[8'h87] = 1;
    occ[8'h88] = 1;
  endtask

  task automatic do_step(input logic [1:0] dir, input logic grow,
                         input bit with_food, input string tag,
                         output logic [11:0] last_w);
    logic [7:0]  hd, pv, nh;
    logic [1:0]  d, in_s;
    logic [3:0]  nk;
    logic        g;
    bit          exp_hit;
    logic [11:0] ew[$];
    int          t, acc, lat;
    hd = body[body.size()-1];
    pv = body[body.size()-2];
    d = dir;
    if (mv(hd, d) == pv) d = side(pv, hd);
    nh = mv(hd, d);
    g = grow && (body.size() < MAX_LEN + 1);
    if (!g) begin
      ew.push_back({body[0], 4'h0});
      ew.push_back({body[1], 4'h8 + {2'b00, side(body[1], body[2])}});
    end
    in_s = side(hd, pv);
    if ((in_s ^ d) == 2'd1) nk = in_s[1] ? 4'h3 : 4'h2;
    else nk = 4'h4 + ((in_s == 2'd1 || d == 2'd1) ? 4'h1 : 4'h0)
                   + ((in_s == 2'd3 || d == 2'd3) ? 4'h2 : 4'h0);
    ew.push_back({hd, nk});
    ew.push_back({nh, 4'hC + {2'b00, d}});
    if (!g) begin
      occ[body[0]] = 0;
      void'(body.pop_front());
    end
    exp_hit = BODY_CHK && occ[nh];
    occ[nh] = 1;
    body.push_back(nh);

    t = 0;
    @(negedge clk);
    while (step_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (step_ready !== 1'b1)
      $display("FAIL %s step_ready_wait: got %b want 1", tag, step_ready);
    else n_pass++;
    wq.delete();
    done_seen = 0;
    step_dir = dir;
    step_grow = grow;
    step_valid = 1'b1;
    acc = cyc;
    if (with_food) begin
      food_x = 4'($urandom);
      food_y = 4'($urandom);
      food_valid = 1'b1;
      #1;
      n_chk++;
      if (food_ready !== 1'b0 || step_ready !== 1'b1)
        $display("FAIL %s priority_ready: got food=%b step=%b want food=0 step=1",
                 tag, food_ready, step_ready);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    food_valid = 1'b0;
    t = 0;
    while (!done_seen && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_chk++;
    if (!done_seen) $display("FAIL %s step_done_timeout: got none want pulse", tag);
    else n_pass++;
    lat = done_cyc - acc;
    n_chk++;
    if (lat != (g ? 3 : 5))
      $display("FAIL %s latency: got %0d want %0d", tag, lat, g ? 3 : 5);
    else n_pass++;
    n_chk++;
    if (wq.size() != ew.size())
      $display("FAIL %s write_count: got %0d want %0d", tag, wq.size(), ew.size());
    else n_pass++;
    for (int i = 0; i < wq.size() && i < ew.size(); i++) begin
      n_chk++;
      if (wq[i] !== ew[i])
        $display("FAIL %s write[%0d]: got %h want %h", tag, i, wq[i], ew[i]);
      else n_pass++;
    end
    n_chk++;
    if (length !== 7'(body.size()))
      $display("FAIL %s length: got %0d want %0d", tag, length, body.size());
    else n_pass++;
    n_chk++;
    if (hit_seen !== exp_hit)
      $display("FAIL %s hit: got %b want %b", tag, hit_seen, exp_hit);
    else n_pass++;
    last_w = (wq.size() > 0) ? wq[wq.size()-1] : 12'hxxx;
  endtask

  task automatic do_food(input logic [3:0] x, input logic [3:0] y, input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (food_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (food_ready !== 1'b1)
      $display("FAIL %s food_ready_wait: got %b want 1", tag, food_ready);
    else n_pass++;
    wq.delete();
    food_x = x;
    food_y = y;
    food_valid = 1'b1;
    @(posedge clk);
    #1;
    food_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (wq.size() != 1 || wq[0] !== {y, x, 4'h1})
      $display("FAIL %s food_write: got n=%0d w=%h want %h", tag, wq.size(),
               (wq.size() > 0) ? wq[0] : 12'h000, {y, x, 4'h1});
    else n_pass++;
  endtask

  task automatic test_reset;
    run_reset("reset");
  endtask

  task automatic test_basic;
    logic [11:0] w;
    do_step(2'd1, 1'b0, 0, "right", w);
    n_chk++;
    if (w !== 12'h89D) $display("FAIL basic_right_head: got %h want 89D", w);
    else n_pass++;
    do_step(2'd2, 1'b1, 0, "up_grow", w);
    n_chk++;
    if (w !== 12'h79E || length !== 7'd4)
      $display("FAIL basic_up_grow: got %h len %0d want 79E len 4", w, length);
    else n_pass++;
    do_step(2'd1, 1'b0, 0, "right2", w);
    do_step(2'd0, 1'b0, 0, "reversal", w);
    n_chk++;
    if (w !== 12'h7BD) $display("FAIL basic_reversal: got %h want 7BD", w);
    else n_pass++;
  endtask

  task automatic test_wrap;
    logic [11:0] w;
    for (int i = 0; i < 4; i++) do_step(2'd1, 1'b0, 0, "wrap_run", w);
    n_chk++;
    if (w[11:4] !== 8'h7F) $display("FAIL wrap_edge: got %h want 7F", w[11:4]);
    else n_pass++;
    do_step(2'd1, 1'b0, 0, "wrap", w);
    n_chk++;
    if (w !== 12'h70D) $display("FAIL wrap_head: got %h want 70D", w);
    else n_pass++;
  endtask

  task automatic test_priority;
    logic [11:0] w;
    do_step(2'($urandom_range(0, 3)), 1'b0, 1, "priority", w);
    do_step(2'($urandom_range(0, 3)), 1'b1, 1, "priority_grow", w);
  endtask

  task automatic test_food;
    do_food(4'h0, 4'h0, "food_corner");
    do_food(4'hF, 4'hF, "food_far");
    do_food(4'($urandom), 4'($urandom), "food_rand");
  endtask

  task automatic test_hit;
    logic [11:0] w;
    run_reset("hit_reset");
    do_step(2'd1, 1'b1, 0, "hit_r", w);
    do_step(2'd2, 1'b1, 0, "hit_u", w);
    do_step(2'd0, 1'b1, 0, "hit_l", w);
    do_step(2'd3, 1'b1, 0, "hit_d", w);
    n_chk++;
    if (hit_seen !== BODY_CHK)
      $display("FAIL hit_loop: got %b want %b", hit_seen, BODY_CHK);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [11:0] w;
    run_reset("rand_reset");
    for (int i = 0; i < 150; i++) begin
      do_step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0), "random", w);
      if ($urandom_range(0, 9) == 0)
        do_food(4'($urandom), 4'($urandom), "rand_food");
    end
  endtask

  task automatic test_full;
    logic [11:0] w;
    for (int i = 0; i < 70; i++)
      do_step(2'($urandom_range(0, 3)), 1'b1, 0, "full", w);
    n_chk++;
    if (length !== 7'(MAX_LEN + 1))
      $display("FAIL full_cap: got %0d want %0d", length, MAX_LEN + 1);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int t;
    t = 0;
    @(negedge clk);
    while (step_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    step_dir = 2'd2;
    step_grow = 1'b0;
    step_valid = 1'b1;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (wr_en !== 1'b1) $display("FAIL mid_busy: got wr_en=%b want 1", wr_en);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (wr_en !== 1'b0) $display("FAIL mid_abort: got wr_en=%b want 0", wr_en);
    else n_pass++;
    run_reset("mid_reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_priority();
    test_food();
    test_hit();
    test_random();
    test_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
